// File: rtl/sig_capture_pkg.sv
// Shared definitions for the triggered signal-capture buffer: FSM state
// codes as reported in STATUS, APB register offsets and CTRL bit positions.
package sig_capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [7:0] OFF_CTRL       = 8'h00;
   localparam logic [7:0] OFF_STATUS     = 8'h04;
   localparam logic [7:0] OFF_TRIG_LEVEL = 8'h08;
   localparam logic [7:0] OFF_TRIG_CFG   = 8'h0C;
   localparam logic [7:0] OFF_PRE_COUNT  = 8'h10;
   localparam logic [7:0] OFF_POST_COUNT = 8'h14;
   localparam logic [7:0] OFF_TRIG_ADDR  = 8'h18;
   localparam logic [7:0] OFF_START_ADDR = 8'h1C;
   localparam logic [7:0] OFF_RD_ADDR    = 8'h20;
   localparam logic [7:0] OFF_RD_DATA    = 8'h24;

   localparam int CTRL_ARM   = 0;
   localparam int CTRL_ABORT = 1;
   localparam int CTRL_FORCE = 2;

endpackage

// File: rtl/sig_capture_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port.
// No reset on the array or the read register so it maps onto block RAM.
module sig_capture_ram #(
   parameter int ADDR_W = 10,
   parameter int WIDTH  = 8
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem_q [0:DEPTH-1];

   // Write port plus registered read port (read-old-data on collision).
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_o <= mem_q[raddr_i];
   end

endmodule

// File: rtl/sig_capture.sv
// Triggered capture buffer for the DDS output. Records a pre/post-trigger
// window into a ring buffer and exposes configuration and readback over APB.
module sig_capture
   import sig_capture_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    penable,
   input  logic                    psel,
   input  logic [31:0]             paddr,
   input  logic                    pwrite,
   input  logic [31:0]             pwdata,
   output logic [31:0]             prdata,
   input  logic signed [WIDTH-1:0] sig,
   input  logic                    sig_valid,
   output logic                    done
);

   // APB decode
   logic [7:0] off_s;
   logic       wr_s;
   logic       rd_acc_s;
   logic       ctrl_wr_s;
   logic       arm_s;
   logic       abort_s;
   logic       force_s;

   // Software-visible configuration
   logic signed [WIDTH-1:0] level_q;
   logic                    edge_q;
   logic [ADDR_W-1:0]       pre_cnt_q;
   logic [ADDR_W-1:0]       post_cnt_q;
   logic [ADDR_W-1:0]       rd_addr_q;

   // Capture engine state
   state_e                  state_q;
   logic [ADDR_W-1:0]       wp_q;
   logic [ADDR_W-1:0]       cnt_q;
   logic [ADDR_W-1:0]       pre_eff_q;
   logic [ADDR_W-1:0]       post_eff_q;
   logic [ADDR_W-1:0]       post_eff_d;
   logic [ADDR_W-1:0]       trig_addr_q;
   logic [ADDR_W-1:0]       start_addr_q;
   logic signed [WIDTH-1:0] prev_q;
   logic                    prev_valid_q;
   logic                    force_pend_q;
   logic                    done_q;

   logic                    edge_hit_s;
   logic                    fire_s;
   logic                    we_s;
   logic [WIDTH-1:0]        ram_rdata_s;
   logic [31:0]             rdata_s;
   logic                    unused_s;

   assign off_s     = paddr[7:0];
   assign wr_s      = psel & penable & pwrite;
   assign rd_acc_s  = psel & penable & ~pwrite;
   assign ctrl_wr_s = wr_s & (off_s == OFF_CTRL);
   assign arm_s     = ctrl_wr_s & pwdata[CTRL_ARM];
   assign abort_s   = ctrl_wr_s & pwdata[CTRL_ABORT];
   assign force_s   = ctrl_wr_s & pwdata[CTRL_FORCE];
   assign done      = done_q;
   assign unused_s  = ^{paddr[31:8], pwdata};

   // Configuration registers and the auto-incrementing readback pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         level_q    <= '0;
         edge_q     <= 1'b0;
         pre_cnt_q  <= '0;
         post_cnt_q <= '0;
         rd_addr_q  <= '0;
      end else begin
         if (wr_s && off_s == OFF_TRIG_LEVEL) level_q    <= pwdata[WIDTH-1:0];
         if (wr_s && off_s == OFF_TRIG_CFG)   edge_q     <= pwdata[0];
         if (wr_s && off_s == OFF_PRE_COUNT)  pre_cnt_q  <= pwdata[ADDR_W-1:0];
         if (wr_s && off_s == OFF_POST_COUNT) post_cnt_q <= pwdata[ADDR_W-1:0];
         if (wr_s && off_s == OFF_RD_ADDR) begin
            rd_addr_q <= pwdata[ADDR_W-1:0];
         end else if (rd_acc_s && off_s == OFF_RD_DATA) begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
         end
      end
   end

   // Post-trigger length clipped so the whole window fits in the ring.
   always_comb begin
      post_eff_d = post_cnt_q;
      if (post_cnt_q > ~pre_cnt_q) begin
         post_eff_d = ~pre_cnt_q;
      end else begin
         post_eff_d = post_cnt_q;
      end
   end

   // Level-crossing detector; needs a previous sample seen in ARMED.
   always_comb begin
      edge_hit_s = 1'b0;
      if (!prev_valid_q) begin
         edge_hit_s = 1'b0;
      end else if (edge_q) begin
         edge_hit_s = (prev_q > level_q) && (sig <= level_q);
      end else begin
         edge_hit_s = (prev_q < level_q) && (sig >= level_q);
      end
   end

   // Trigger qualification and RAM write enable (control pulses win).
   always_comb begin
      fire_s = 1'b0;
      we_s   = 1'b0;
      if (state_q == ST_ARMED && sig_valid) begin
         fire_s = edge_hit_s | force_pend_q | force_s;
      end else begin
         fire_s = 1'b0;
      end
      if (sig_valid && !arm_s && !abort_s) begin
         case (state_q)
            ST_PRE:   we_s = (pre_eff_q != ADDR_W'(0));
            ST_ARMED: we_s = 1'b1;
            ST_POST:  we_s = 1'b1;
            default:  we_s = 1'b0;
         endcase
      end else begin
         we_s = 1'b0;
      end
   end

   // Capture FSM: ABORT beats ARM, ARM restarts from any state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         wp_q         <= '0;
         cnt_q        <= '0;
         pre_eff_q    <= '0;
         post_eff_q   <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         force_pend_q <= 1'b0;
         done_q       <= 1'b0;
      end else if (abort_s) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         force_pend_q <= 1'b0;
         done_q       <= 1'b0;
      end else if (arm_s) begin
         state_q      <= ST_PRE;
         wp_q         <= '0;
         cnt_q        <= '0;
         prev_valid_q <= 1'b0;
         force_pend_q <= 1'b0;
         done_q       <= 1'b0;
         pre_eff_q    <= pre_cnt_q;
         post_eff_q   <= post_eff_d;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
            end
            ST_PRE: begin
               if (pre_eff_q == ADDR_W'(0)) begin
                  state_q <= ST_ARMED;
               end else if (sig_valid) begin
                  wp_q <= wp_q + ADDR_W'(1);
                  if (cnt_q == pre_eff_q - ADDR_W'(1)) begin
                     state_q <= ST_ARMED;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + ADDR_W'(1);
                  end
               end
            end
            ST_ARMED: begin
               if (force_s) force_pend_q <= 1'b1;
               if (sig_valid) begin
                  wp_q         <= wp_q + ADDR_W'(1);
                  prev_q       <= sig;
                  prev_valid_q <= 1'b1;
                  if (fire_s) begin
                     trig_addr_q  <= wp_q;
                     start_addr_q <= wp_q - pre_eff_q;
                     force_pend_q <= 1'b0;
                     cnt_q        <= '0;
                     if (post_eff_q == ADDR_W'(0)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_POST;
                     end
                  end
               end
            end
            ST_POST: begin
               if (sig_valid) begin
                  wp_q <= wp_q + ADDR_W'(1);
                  if (cnt_q == post_eff_q - ADDR_W'(1)) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + ADDR_W'(1);
                  end
               end
            end
            ST_DONE: begin
               done_q <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   sig_capture_ram #(
      .ADDR_W (ADDR_W),
      .WIDTH  (WIDTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (we_s),
      .waddr_i (wp_q),
      .wdata_i (sig),
      .raddr_i (rd_addr_q),
      .rdata_o (ram_rdata_s)
   );

   // Read-data mux on the low address byte; unmapped offsets read zero.
   always_comb begin
      rdata_s = 32'd0;
      case (off_s)
         OFF_STATUS:     rdata_s[2:0]        = state_q;
         OFF_TRIG_LEVEL: rdata_s[WIDTH-1:0]  = level_q;
         OFF_TRIG_CFG:   rdata_s[0]          = edge_q;
         OFF_PRE_COUNT:  rdata_s[ADDR_W-1:0] = pre_cnt_q;
         OFF_POST_COUNT: rdata_s[ADDR_W-1:0] = post_cnt_q;
         OFF_TRIG_ADDR:  rdata_s[ADDR_W-1:0] = trig_addr_q;
         OFF_START_ADDR: rdata_s[ADDR_W-1:0] = start_addr_q;
         OFF_RD_ADDR:    rdata_s[ADDR_W-1:0] = rd_addr_q;
         OFF_RD_DATA:    rdata_s = {{(32-WIDTH){ram_rdata_s[WIDTH-1]}}, ram_rdata_s};
         default:        rdata_s = 32'd0;
      endcase
   end

   // Bus only driven during reads; forced low while in reset.
   assign prdata = (reset && psel && !pwrite) ? rdata_s : 32'd0;

endmodule

// File: tb/tb_sig_capture.sv
// Directed self-checking bench for sig_capture.
module tb_sig_capture;

   localparam logic [31:0] A_CTRL   = 32'h00;
   localparam logic [31:0] A_STATUS = 32'h04;
   localparam logic [31:0] A_LEVEL  = 32'h08;
   localparam logic [31:0] A_CFG    = 32'h0C;
   localparam logic [31:0] A_PRE    = 32'h10;
   localparam logic [31:0] A_POST   = 32'h14;
   localparam logic [31:0] A_TRIG   = 32'h18;
   localparam logic [31:0] A_START  = 32'h1C;
   localparam logic [31:0] A_RDADDR = 32'h20;
   localparam logic [31:0] A_RDDATA = 32'h24;

   logic               clk = 1'b0;
   logic               reset;
   logic               penable;
   logic               psel;
   logic [31:0]        paddr;
   logic               pwrite;
   logic [31:0]        pwdata;
   logic [31:0]        prdata;
   logic signed [7:0]  sig;
   logic               sig_valid;
   logic               done;

   int checks   = 0;
   int failures = 0;

   sig_capture #(.ADDR_W(10), .WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .penable   (penable),
      .psel      (psel),
      .paddr     (paddr),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .sig       (sig),
      .sig_valid (sig_valid),
      .done      (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      psel = 1'b1; pwrite = 1'b1; paddr = addr; pwdata = data; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      psel = 1'b1; pwrite = 1'b0; paddr = addr; penable = 1'b0;
      @(negedge clk);
      penable = 1'b1;
      #1 data = prdata;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [31:0] addrs [8];
      addrs = '{A_STATUS, A_LEVEL, A_CFG, A_PRE, A_POST, A_TRIG, A_START, A_RDADDR};
      reset = 1'b0; sig_valid = 1'b1; sig = -8'sd128;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         sig = sig + 8'sd17;
      end
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", done); end
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL rst_prdata_status: got %h expected 0", d); end
      apb_read(A_RDDATA, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL rst_prdata_rddata: got %h expected 0", d); end
      @(negedge clk);
      reset = 1'b1; sig_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         apb_read(addrs[i], d);
         checks++;
         if (d !== 32'd0) begin failures++; $display("FAIL post_rst_reg%0d: got %h expected 0", i, d); end
      end
      checks++;
      if (prdata !== 32'd0) begin failures++; $display("FAIL idle_prdata: got %h expected 0", prdata); end
   endtask

   task automatic test_regs();
      logic [31:0] d;
      apb_write(A_LEVEL, 32'h0000_01A5);
      apb_read(A_LEVEL, d);
      checks++;
      if (d !== 32'h0000_00A5) begin failures++; $display("FAIL level_rw: got %h expected a5", d); end
      apb_read(32'h0000_0108, d);
      checks++;
      if (d !== 32'h0000_00A5) begin failures++; $display("FAIL addr_alias: got %h expected a5", d); end
      apb_write(A_CFG, 32'h3);
      apb_read(A_CFG, d);
      checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL cfg_rw: got %h expected 1", d); end
      apb_write(A_PRE, 32'hFFFF_F7FF);
      apb_read(A_PRE, d);
      checks++;
      if (d !== 32'h3FF) begin failures++; $display("FAIL pre_rw: got %h expected 3ff", d); end
      apb_write(A_RDADDR, 32'h0001_2345);
      apb_read(A_RDADDR, d);
      checks++;
      if (d !== 32'h345) begin failures++; $display("FAIL rdaddr_rw: got %h expected 345", d); end
      apb_read(A_CTRL, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL ctrl_reads0: got %h expected 0", d); end
      apb_read(32'h40, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL unmapped: got %h expected 0", d); end
   endtask

   // Rising trigger at level 0 on a ramp from -10; trigger sample at wp 10.
   task automatic run_ramp(input bit half, input string tag);
      logic [31:0] d;
      int v;
      int n;
      bit phase;
      sig_valid = 1'b0;
      apb_write(A_PRE, 32'd4);
      apb_write(A_POST, 32'd3);
      apb_write(A_LEVEL, 32'd0);
      apb_write(A_CFG, 32'd0);
      apb_write(A_CTRL, 32'h1);
      v = -10; n = 0; phase = 1'b0;
      while (n < 20) begin
         if (half && phase) begin
            sig_valid = 1'b0; sig = 8'sd100;
         end else begin
            sig_valid = 1'b1; sig = 8'(v); v++; n++;
         end
         phase = !phase;
         @(negedge clk);
      end
      sig_valid = 1'b0;
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL %s_done: got %b expected 1", tag, done); end
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd4) begin failures++; $display("FAIL %s_status: got %h expected 4", tag, d); end
      apb_read(A_TRIG, d);
      checks++;
      if (d !== 32'd10) begin failures++; $display("FAIL %s_trig: got %h expected a", tag, d); end
      apb_read(A_START, d);
      checks++;
      if (d !== 32'd6) begin failures++; $display("FAIL %s_start: got %h expected 6", tag, d); end
      apb_write(A_RDADDR, 32'd6);
      for (int i = 0; i < 8; i++) begin
         int e;
         e = i - 4;
         apb_read(A_RDDATA, d);
         checks++;
         if (d !== 32'(e)) begin failures++; $display("FAIL %s_data%0d: got %h expected %h", tag, i, d, 32'(e)); end
      end
   endtask

   task automatic test_ramp();
      run_ramp(1'b0, "ramp");
   endtask

   task automatic test_falling();
      logic [31:0] d;
      logic signed [7:0] pat [10];
      logic [31:0] exp_rd [5];
      pat    = '{8'sd5, 8'sd5, 8'sd20, 8'sd20, 8'sd5, 8'sd5, 8'sd20, 8'sd20, 8'sd5, 8'sd5};
      exp_rd = '{32'd20, 32'd20, 32'd5, 32'd5, 32'd20};
      sig_valid = 1'b1; sig = 8'sd5;
      apb_write(A_PRE, 32'd2);
      apb_write(A_POST, 32'd2);
      apb_write(A_LEVEL, 32'd10);
      apb_write(A_CFG, 32'd1);
      apb_write(A_CTRL, 32'h1);
      for (int i = 0; i < 10; i++) begin
         sig = pat[i];
         @(negedge clk);
      end
      sig_valid = 1'b0;
      apb_read(A_TRIG, d);
      checks++;
      if (d !== 32'd4) begin failures++; $display("FAIL fall_trig: got %h expected 4", d); end
      apb_read(A_START, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL fall_start: got %h expected 2", d); end
      apb_write(A_RDADDR, 32'd2);
      for (int i = 0; i < 5; i++) begin
         apb_read(A_RDDATA, d);
         checks++;
         if (d !== exp_rd[i]) begin failures++; $display("FAIL fall_data%0d: got %h expected %h", i, d, exp_rd[i]); end
      end
   endtask

   // PRE clipped window: post_eff=0, trigger at sample 1024 lands on wp 0.
   task automatic test_max_window();
      logic [31:0] d;
      sig_valid = 1'b0;
      apb_write(A_PRE, 32'd1023);
      apb_write(A_POST, 32'd500);
      apb_write(A_LEVEL, 32'd0);
      apb_write(A_CFG, 32'd0);
      apb_write(A_CTRL, 32'h1);
      for (int n = 0; n <= 1024; n++) begin
         sig_valid = 1'b1; sig = 8'(n);
         @(negedge clk);
         if (n == 1023) begin
            checks++;
            if (done !== 1'b0) begin failures++; $display("FAIL max_early_done: got %b expected 0", done); end
         end
         if (n == 1024) begin
            checks++;
            if (done !== 1'b1) begin failures++; $display("FAIL max_done_next: got %b expected 1", done); end
         end
      end
      sig_valid = 1'b0;
      apb_read(A_TRIG, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL max_trig: got %h expected 0", d); end
      apb_read(A_START, d);
      checks++;
      if (d !== 32'd1) begin failures++; $display("FAIL max_start: got %h expected 1", d); end
      apb_write(A_RDADDR, 32'd1);
      for (int i = 0; i < 1024; i++) begin
         logic [7:0] b;
         logic [31:0] e;
         b = 8'(i + 1);
         e = {{24{b[7]}}, b};
         apb_read(A_RDDATA, d);
         checks++;
         if (d !== e) begin failures++; $display("FAIL max_data%0d: got %h expected %h", i, d, e); end
      end
      apb_read(A_RDADDR, d);
      checks++;
      if (d !== 32'd1) begin failures++; $display("FAIL max_rdaddr_wrap: got %h expected 1", d); end
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      @(negedge clk);
      checks++;
      if (done !== 1'b1) begin failures++; $display("FAIL async_pre_done: got %b expected 1", done); end
      reset = 1'b0;
      #1;
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL async_done_clear: got %b expected 0", done); end
      @(negedge clk);
      reset = 1'b1;
      apb_read(A_PRE, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL async_pre_cleared: got %h expected 0", d); end
   endtask

   task automatic test_force();
      logic [31:0] d;
      sig_valid = 1'b0; sig = 8'sd7;
      apb_write(A_PRE, 32'd0);
      apb_write(A_POST, 32'd0);
      apb_write(A_LEVEL, 32'd0);
      apb_write(A_CFG, 32'd0);
      apb_write(A_CTRL, 32'h1);
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL force_armed: got %h expected 2", d); end
      sig_valid = 1'b1;
      repeat (5) @(negedge clk);
      sig_valid = 1'b0;
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL const_no_trig: got %h expected 2", d); end
      apb_write(A_CTRL, 32'h4);
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL force_waits_valid: got %h expected 2", d); end
      sig_valid = 1'b1;
      @(negedge clk);
      sig_valid = 1'b0;
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd4) begin failures++; $display("FAIL force_done: got %h expected 4", d); end
      apb_read(A_TRIG, d);
      checks++;
      if (d !== 32'd5) begin failures++; $display("FAIL force_trig: got %h expected 5", d); end
      apb_write(A_CTRL, 32'h2);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL abort_done_clr: got %b expected 0", done); end
      apb_write(A_CTRL, 32'h4);
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL force_idle: got %h expected 0", d); end
      apb_write(A_CTRL, 32'h1);
      sig_valid = 1'b1;
      repeat (4) @(negedge clk);
      sig_valid = 1'b0;
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL no_stale_force: got %h expected 2", d); end
      apb_write(A_CTRL, 32'h2);
   endtask

   task automatic enter_post();
      sig_valid = 1'b0; sig = 8'sd7;
      apb_write(A_PRE, 32'd0);
      apb_write(A_POST, 32'd10);
      apb_write(A_CTRL, 32'h1);
      apb_write(A_CTRL, 32'h4);
      sig_valid = 1'b1;
      repeat (3) @(negedge clk);
      sig_valid = 1'b0;
   endtask

   task automatic test_abort();
      logic [31:0] d;
      enter_post();
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd3) begin failures++; $display("FAIL abort_in_post: got %h expected 3", d); end
      apb_write(A_CTRL, 32'h2);
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL abort_idle: got %h expected 0", d); end
      enter_post();
      apb_write(A_CTRL, 32'h1);
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd2) begin failures++; $display("FAIL rearm_restart: got %h expected 2", d); end
      apb_write(A_CTRL, 32'h3);
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL abort_beats_arm: got %h expected 0", d); end
   endtask

   task automatic test_reset_mid_post();
      logic [31:0] d;
      enter_post();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      apb_read(A_STATUS, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL rst_post_idle: got %h expected 0", d); end
      apb_read(A_POST, d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL rst_post_cfg: got %h expected 0", d); end
      run_ramp(1'b0, "rearm");
   endtask

   task automatic test_half_valid();
      run_ramp(1'b1, "half");
   endtask

   initial begin
      reset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 32'd0; pwdata = 32'd0; sig = 8'sd0; sig_valid = 1'b0;
      test_reset();
      test_regs();
      test_ramp();
      test_falling();
      test_max_window();
      test_async_reset();
      test_force();
      test_abort();
      test_reset_mid_post();
      test_half_valid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sig_capture.md
Name: sig_capture

Overview:
- Triggered capture buffer downstream of the DDS block; consumes the signed 8-bit generator output (dds_data_out) at clk rate.
- Records a programmable pre-/post-trigger window into on-chip RAM.
- Software reads the window back over the same APB bus used by the DDS registers, for scope-style display of the generated signal.

Parameters:
- ADDR_W, 10, log2 of buffer depth (DEPTH = 2**ADDR_W samples).
- WIDTH, 8, sample width (signed).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- penable  in  1  APB enable
- psel  in  1  APB select
- paddr  in  32  APB address; only paddr[7:0] decoded
- pwrite  in  1  APB write
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- sig  in  WIDTH  signed sample (dds_data_out)
- sig_valid  in  1  sample qualifier
- done  out  1  level; high in DONE state

Behaviour:
- Reset: reset is asynchronous, active-low; clk is the only clock. While reset is low:
  - state=IDLE, all registers 0, done=0, prdata=0.
  - RAM contents undefined.
- Register map (offset, access):
  - 0x00 CTRL (W): bit0 ARM, bit1 ABORT, bit2 FORCE. Write-1 single-cycle pulses; reads 0.
  - 0x04 STATUS (R): [2:0] state code.
  - 0x08 TRIG_LEVEL (RW): [7:0] signed.
  - 0x0C TRIG_CFG (RW): bit0 edge (0=rising, 1=falling).
  - 0x10 PRE_COUNT (RW): [ADDR_W-1:0].
  - 0x14 POST_COUNT (RW): [ADDR_W-1:0].
  - 0x18 TRIG_ADDR (R): RAM index of the trigger sample.
  - 0x1C START_ADDR (R): equals TRIG_ADDR-pre_eff mod DEPTH.
  - 0x20 RD_ADDR (RW).
  - 0x24 RD_DATA (R): sign-extended to 32 bits.
  - Unmapped offsets read 0.
- APB timing:
  - Writes take effect on psel&penable&pwrite.
  - prdata is a combinational mux on paddr[7:0], gated by psel&!pwrite; 0 otherwise.
- Readback:
  - RAM read port is synchronous (1 cycle); its address is RD_ADDR, so RD_DATA always holds mem[RD_ADDR] one cycle after RD_ADDR changes.
  - An access-phase read of RD_DATA returns the current value, then increments RD_ADDR mod DEPTH.
  - APB's 2-cycle minimum transfer guarantees the next value is valid.
- Effective counts, latched at ARM:
  - pre_eff = min(PRE_COUNT, DEPTH-1).
  - post_eff = min(POST_COUNT, DEPTH-1-pre_eff).
- Write pointer wp advances mod DEPTH on every sig_valid sample written; samples are written only in PRE, ARMED and POST.
- States (code):
  - IDLE(0): on ARM, clear wp, sample counter and the prev-sample-valid flag; go to PRE.
  - PRE(1): write samples; after pre_eff samples go to ARMED; if pre_eff=0, go to ARMED immediately on the next cycle.
  - ARMED(2): keep writing (ring wraps). Trigger fires on a valid sample when:
    - rising edge: prev<LEVEL and cur>=LEVEL (signed compare);
    - falling edge: prev>LEVEL and cur<=LEVEL;
    - FORCE: triggers on the next valid sample regardless of level.
    - The first valid sample after entry into ARMED has no prev, so it cannot trigger except by FORCE.
    - On trigger: TRIG_ADDR=wp of the trigger sample, that sample is written, go to POST (or to DONE if post_eff=0).
  - POST(3): write post_eff further samples, then go to DONE.
  - DONE(4): no writes; done=1; START_ADDR valid; stays until ARM or ABORT.
- Control priority and boundaries:
  - ABORT in any state: go to IDLE next cycle, done=0. ABORT beats ARM if both are written together.
  - ARM in a non-IDLE state restarts the sequence (same effect as ARM from IDLE).
  - FORCE outside ARMED is ignored.
  - sig_valid=0 stalls all counters and the edge detector (prev is held).
  - Register writes to LEVEL/CFG/COUNT take effect for the comparator immediately; counts only at the next ARM.

Decomposition:
- Package sig_capture_pkg:
  - state enum (IDLE, PRE, ARMED, POST, DONE with the codes above);
  - register offset localparams;
  - CTRL bit indices.
- One sub-module, sig_capture_ram: simple dual-port RAM, DEPTH x WIDTH, one write port and one synchronous read port, block-RAM inferable.

Test Plan:
- Reset with sig a ramp -> STATUS=0, done=0, prdata=0 on all reads, no RAM writes.
- PRE=4, POST=3, LEVEL=0, rising; sig=-128..127 ramp, sig_valid=1, ARM:
  - -> trigger on sample 0;
  - START_ADDR=TRIG_ADDR-4;
  - 8 RD_DATA reads from START_ADDR return -4..3 (sign-extended, e.g. 0xFFFFFFFC);
  - done=1.
- Falling edge, LEVEL=10, sig toggling 20/5 every 2 cycles -> trigger on first 5 sample following 20; TRIG_ADDR matches.
- PRE=1023, POST=500 (ADDR_W=10) -> post_eff=0; DONE on the cycle after trigger; 1024 reads wrap RD_ADDR 1023->0.
- Constant sig (no edge), FORCE in ARMED -> trigger next valid sample; FORCE in IDLE -> STATUS stays 0.
- ABORT mid-POST -> IDLE next cycle, done=0. Reset asserted mid-POST -> immediate IDLE; re-ARM completes normally. Toggling sig_valid at 50% -> same captured data as the contiguous run.
